// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle for serial_sub_ctrl
//   master: drives start, a, b, bin; receives busy, done, diff, bout
//   slave : the controller side of the same signals
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b - bin using one external shared 1-bit full subtractor
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : start/a/b/bin request, busy/done/diff/bout result
//   fs_a/fs_b/fs_bin : operand bit and borrow presented to the full subtractor
//   fs_diff/fs_bout  : full-subtractor results captured in RUN
//   SERIAL_SUB_SETTLE_EN: adds SETTLE_CYC wait cycles per bit before each capture
module serial_sub_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_sub_if.slave   bus,
    output logic          fs_a,
    output logic          fs_b,
    output logic          fs_bin,
    input  logic          fs_diff,
    input  logic          fs_bout
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SERIAL_SUB_SETTLE_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, SETTLE} state_t;
    localparam state_t FIRST = SETTLE;
    logic [3:0] cnt;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam state_t FIRST = RUN;
    // SETTLE_CYC has no effect without the settle phase
    logic [31:0] unused_settle;
    assign unused_settle = SETTLE_CYC;
`endif

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
    logic [IW-1:0]    idx;
    logic             borrow_reg, bout_reg, last;

    assign last = idx == IW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? FIRST : IDLE;
            RUN:     state_nx = last ? DONE : FIRST;
`ifdef SERIAL_SUB_SETTLE_EN
            SETTLE:  state_nx = (cnt == 4'(SETTLE_CYC - 1)) ? RUN : SETTLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // fs_* come straight from registers so the shared subtractor sees clean inputs
    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == DONE;
        bus.diff = diff_reg;
        bus.bout = bout_reg;
        fs_a     = a_reg[idx];
        fs_b     = b_reg[idx];
        fs_bin   = borrow_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            idx        <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                a_reg      <= bus.a;
                b_reg      <= bus.b;
                borrow_reg <= bus.bin;
                idx        <= '0;
            end
            if (state == RUN) begin
                diff_reg[idx] <= fs_diff;
                borrow_reg    <= fs_bout;
                if (last) bout_reg <= fs_bout;
                else      idx      <= idx + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_SETTLE_EN
    // cnt restarts on every entry into SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (state == SETTLE) ? cnt + 4'd1 : 4'd0;
    end
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed self-checking bench for serial_sub_ctrl (WIDTH=8 and WIDTH=1)
module tb_serial_sub_ctrl;
    localparam int S = 2;
`ifdef SERIAL_SUB_SETTLE_EN
    localparam int LAT8 = 8 * (S + 1);
    localparam int LAT1 = 1 * (S + 1);
`else
    localparam int LAT8 = 8;
    localparam int LAT1 = 1;
`endif

    logic clk, rst_n;
    int   checks, failures, dpulses;

    serial_sub_if #(.WIDTH(8)) i8 ();
    serial_sub_if #(.WIDTH(1)) i1 ();

    logic fa8, fb8, fbi8, fd8, fo8;
    logic fa1, fb1, fbi1, fd1, fo1;

    // external shared full subtractor models
    assign fd8 = fa8 ^ fb8 ^ fbi8;
    assign fo8 = (~fa8 & fb8) | (~(fa8 ^ fb8) & fbi8);
    assign fd1 = fa1 ^ fb1 ^ fbi1;
    assign fo1 = (~fa1 & fb1) | (~(fa1 ^ fb1) & fbi1);

    serial_sub_ctrl #(.WIDTH(8), .SETTLE_CYC(S)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(i8),
        .fs_a(fa8), .fs_b(fb8), .fs_bin(fbi8), .fs_diff(fd8), .fs_bout(fo8)
    );
    serial_sub_ctrl #(.WIDTH(1), .SETTLE_CYC(S)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1),
        .fs_a(fa1), .fs_b(fb1), .fs_bin(fbi1), .fs_diff(fd1), .fs_bout(fo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (i8.done) dpulses++;

    task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        @(negedge clk);
        i8.a = av; i8.b = bv; i8.bin = bi; i8.start = 1'b1;
        @(posedge clk); #1;
        i8.start = 1'b0;
    endtask

    task automatic wait_done8(inout int n);
        while (!i8.done && n < LAT8 + 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i8.start = 0; i8.a = 0; i8.b = 0; i8.bin = 0;
        i1.start = 0; i1.a = 0; i1.b = 0; i1.bin = 0;
        #12;
        checks++; if (i8.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", i8.busy); end
        checks++; if (i8.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", i8.done); end
        checks++; if ({i8.diff, i8.bout} !== 9'h0) begin failures++; $display("FAIL reset_result got=%h exp=000", {i8.diff, i8.bout}); end
        checks++; if ({fa8, fb8, fbi8} !== 3'b000) begin failures++; $display("FAIL reset_fs got=%b exp=000", {fa8, fb8, fbi8}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int n = 0;
        logic [2:0] fs_prev;
        launch8(8'h05, 8'h03, 1'b0);
        checks++; if (i8.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", i8.busy); end
        fs_prev = {fa8, fb8, fbi8};
        while (!i8.done && n < LAT8 + 10) begin
            @(posedge clk); #1;
            n++;
`ifdef SERIAL_SUB_SETTLE_EN
            if (n % (S + 1) != 0 && n < LAT8) begin
                checks++;
                if ({fa8, fb8, fbi8} !== fs_prev) begin
                    failures++; $display("FAIL settle_fs_stable edge=%0d got=%b exp=%b", n, {fa8, fb8, fbi8}, fs_prev);
                end
            end
`endif
            fs_prev = {fa8, fb8, fbi8};
        end
        checks++; if (n !== LAT8) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", n, LAT8); end
        checks++; if (i8.diff !== 8'h02) begin failures++; $display("FAIL basic_diff got=%h exp=02", i8.diff); end
        checks++; if (i8.bout !== 1'b0) begin failures++; $display("FAIL basic_bout got=%b exp=0", i8.bout); end
        @(posedge clk); #1;
        checks++; if ({i8.done, i8.busy} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b exp=00", {i8.done, i8.busy}); end
        checks++; if (i8.diff !== 8'h02) begin failures++; $display("FAIL basic_hold got=%h exp=02", i8.diff); end
    endtask

    task automatic test_borrow;
        logic [16:0] vec [2] = '{{8'h00, 8'h01, 1'b0}, {8'h80, 8'h7F, 1'b1}};
        logic [8:0]  exp [2] = '{{8'hFF, 1'b1}, {8'h00, 1'b0}};
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            launch8(vec[k][16:9], vec[k][8:1], vec[k][0]);
            wait_done8(n);
            checks++; if (n !== LAT8) begin failures++; $display("FAIL borrow_latency[%0d] got=%0d exp=%0d", k, n, LAT8); end
            checks++; if ({i8.diff, i8.bout} !== exp[k]) begin failures++; $display("FAIL borrow_result[%0d] got=%h exp=%h", k, {i8.diff, i8.bout}, exp[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_width1;
        logic [7:0] dtab = 8'b1001_0110;
        logic [7:0] btab = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            @(negedge clk);
            i1.a = i[2]; i1.b = i[1]; i1.bin = i[0]; i1.start = 1'b1;
            @(posedge clk); #1;
            i1.start = 1'b0;
            while (!i1.done && n < LAT1 + 10) begin
                @(posedge clk); #1;
                n++;
            end
            checks++; if (n !== LAT1) begin failures++; $display("FAIL w1_latency[%0d] got=%0d exp=%0d", i, n, LAT1); end
            checks++;
            if ({i1.bout, i1.diff} !== {btab[i], dtab[i]}) begin
                failures++; $display("FAIL w1_result[%0d] got=%b exp=%b", i, {i1.bout, i1.diff}, {btab[i], dtab[i]});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_ignore;
        int n = 0;
        int p0 = dpulses;
        launch8(8'h05, 8'h03, 1'b0);
        @(posedge clk); #1; n++;
        @(negedge clk);
        i8.a = 8'hFF; i8.b = 8'h00; i8.bin = 1'b0; i8.start = 1'b1;
        @(posedge clk); #1; n++;
        i8.start = 1'b0;
        wait_done8(n);
        checks++; if (n !== LAT8) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", n, LAT8); end
        checks++; if ({i8.diff, i8.bout} !== {8'h02, 1'b0}) begin failures++; $display("FAIL ignore_result got=%h exp=004", {i8.diff, i8.bout}); end
        repeat (LAT8 + 4) @(posedge clk);
        #1;
        checks++; if (dpulses - p0 !== 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", dpulses - p0); end
        checks++; if (i8.busy !== 1'b0) begin failures++; $display("FAIL ignore_idle got=%b exp=0", i8.busy); end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        launch8(8'h00, 8'h01, 1'b0);
        wait_done8(n);
        @(posedge clk); #1;
        launch8(8'hFF, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (i8.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", i8.busy); end
        checks++; if ({i8.diff, i8.bout} !== 9'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=000", {i8.diff, i8.bout}); end
        #3;
        rst_n = 1'b1;
        n = 0;
        launch8(8'h10, 8'h01, 1'b1);
        wait_done8(n);
        checks++; if (n !== LAT8) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", n, LAT8); end
        checks++; if ({i8.diff, i8.bout} !== {8'h0E, 1'b0}) begin failures++; $display("FAIL rstmid_result2 got=%h exp=01c", {i8.diff, i8.bout}); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int n = 0;
        launch8(8'h07, 8'h02, 1'b0);
        wait_done8(n);
        checks++; if (i8.diff !== 8'h05) begin failures++; $display("FAIL b2b_first got=%h exp=05", i8.diff); end
        @(negedge clk);
        i8.a = 8'h09; i8.b = 8'h01; i8.bin = 1'b0; i8.start = 1'b1;
        @(posedge clk); #1;
        checks++; if (i8.busy !== 1'b0) begin failures++; $display("FAIL b2b_done_start_ignored got=%b exp=0", i8.busy); end
        checks++; if (i8.diff !== 8'h05) begin failures++; $display("FAIL b2b_hold got=%h exp=05", i8.diff); end
        @(posedge clk); #1;
        checks++; if (i8.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", i8.busy); end
        @(negedge clk);
        i8.start = 1'b0;
        n = 0;
        @(posedge clk); #1; n++;
        wait_done8(n);
        checks++; if (n !== LAT8) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", n, LAT8); end
        checks++; if ({i8.diff, i8.bout} !== {8'h08, 1'b0}) begin failures++; $display("FAIL b2b_result got=%h exp=010", {i8.diff, i8.bout}); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0; failures = 0; dpulses = 0;
        test_reset;
        test_basic;
        test_borrow;
        test_width1;
        test_busy_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1..32.
REQ-002 Parameter SETTLE_CYC, default 2: wait cycles per bit; used only when SERIAL_SUB_SETTLE_EN is defined; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-006 a  input  WIDTH  minuend; captured on the accepted start.
REQ-007 b  input  WIDTH  subtrahend; captured on the accepted start.
REQ-008 bin  input  1  initial borrow-in; captured on the accepted start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  registered final borrow-out.
REQ-013 fs_a, fs_b, fs_bin  output  1 each  drive the external shared 1-bit full subtractor.
REQ-014 fs_diff, fs_bout  input  1 each  results returned by the external full subtractor.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; with SERIAL_SUB_SETTLE_EN it SHALL also have SETTLE.
REQ-016 IDLE with start=1 at an edge: latch a, b, bin; set bit index to 0; go to RUN (or SETTLE when enabled).
REQ-017 IDLE with start=0: no state change.
REQ-018 fs_a=a_reg[idx], fs_b=b_reg[idx], fs_bin=borrow_reg, driven purely from registers (glitch-free).
REQ-019 RUN edge: diff_reg[idx]<=fs_diff, borrow_reg<=fs_bout; if idx==WIDTH-1 go to DONE, else idx+1 (and re-enter SETTLE when enabled).
REQ-020 Without settle: done=1 exactly WIDTH+1 cycles after the accepted start edge; bits are captured at edges 1..WIDTH after start.
REQ-021 DONE: done=1 for exactly one cycle, bout=borrow_reg; next edge goes to IDLE.
REQ-022 diff and bout SHALL hold their values from done until the next accepted start.
REQ-023 start while busy=1 SHALL be ignored; latched operands SHALL remain unchanged.
REQ-024 start asserted in the DONE cycle SHALL be ignored; start held high through the return to IDLE SHALL be accepted on the first IDLE edge.
REQ-025 WIDTH=1: one RUN cycle, then DONE.
REQ-026 The bit index SHALL never exceed WIDTH-1 and SHALL never wrap within an operation.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE and clear busy, done, diff, bout, idx, borrow_reg, a_reg and b_reg to 0, including mid-operation.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-029 Macro SERIAL_SUB_SETTLE_EN defined: each bit spends SETTLE_CYC cycles in SETTLE with fs_* held stable, then one RUN cycle captures the result; done rises WIDTH*(SETTLE_CYC+1)+1 cycles after start. This covers full-subtractor gate delay exceeding one clock period.
REQ-030 Macro SERIAL_SUB_SETTLE_EN undefined: no SETTLE state, SETTLE_CYC is unused, and timing follows REQ-020.

Verification
REQ-031 WIDTH=8, a=0x05, b=0x03, bin=0, start -> done at cycle 9, diff=0x02, bout=0.
REQ-032 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
REQ-033 Exhaustive WIDTH=1: all 8 combinations of {a, b, bin} -> {bout, diff} match the full-subtractor truth table.
REQ-034 Second start with a=0xFF at cycle 3 of a busy operation -> ignored; the first result is unchanged and no extra done pulse occurs.
REQ-035 rst_n pulled low at cycle 4 of an operation -> busy=0, diff=0x00, bout=0 immediately; a new start then completes correctly.
REQ-036 With SERIAL_SUB_SETTLE_EN, SETTLE_CYC=2, WIDTH=8: a=0x05, b=0x03 -> done at cycle 25, diff=0x02, and fs_* are constant during each SETTLE span.
